// File: rtl/mem_sequencer_pkg.sv
// Shared constants for the memory sequencer: state encodings and the NOP
// instruction presented to the core whenever no fetched instruction is valid.
package mem_sequencer_pkg;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_IWAIT  = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_DWAIT  = 3'd4;
    localparam logic [2:0] S_COMMIT = 3'd5;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    // Loader writes are always full-word.
    function automatic logic [3:0] full_lanes(input logic we);
        return we ? 4'hF : 4'h0;
    endfunction

endpackage

// File: rtl/mem_sequencer_retire_counter.sv
// Free-running retired-instruction counter with enable and a synchronous
// active-low clear. Wraps at 2^32.
module retire_counter (
    input  logic        clk,
    input  logic        clr_n,
    input  logic        en,
    output logic [31:0] count
);

    logic [31:0] count_q;
    logic [31:0] count_d;

    // Next count: increment once per enabled cycle.
    always_comb begin
        count_d = count_q;
        if (en) begin
            count_d = count_q + 32'd1;
        end
    end

    // Count register with synchronous clear.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/mem_sequencer.sv
// Multi-cycle sequencer letting a single-cycle core share one single-port
// synchronous BRAM between instruction fetch, data access and a loader.
// The fetched instruction and loaded data are held in registers; the core
// is stalled except in the single commit cycle of each instruction.
module mem_sequencer
    import mem_sequencer_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run,
    input  logic [ADDR_WIDTH-1:0] c_i_r_addr,
    output logic [DATA_WIDTH-1:0] c_i_r_dat,
    input  logic [ADDR_WIDTH-1:0] c_d_r_addr,
    input  logic                  c_d_r_enb,
    output logic [DATA_WIDTH-1:0] c_d_r_dat,
    input  logic [ADDR_WIDTH-1:0] c_d_w_addr,
    input  logic [DATA_WIDTH-1:0] c_d_w_dat,
    input  logic                  c_d_w_enb,
    input  logic [3:0]            c_d_w_byte_enb,
    output logic                  pc_stall,
    output logic                  wb_en,
    output logic [ADDR_WIDTH-1:0] m_addr,
    output logic                  m_en,
    output logic [3:0]            m_we,
    output logic [DATA_WIDTH-1:0] m_wdat,
    input  logic [DATA_WIDTH-1:0] m_rdat,
    output logic                  ld_ready,
    input  logic                  ld_en,
    input  logic                  ld_we,
    input  logic [ADDR_WIDTH-1:0] ld_addr,
    input  logic [DATA_WIDTH-1:0] ld_wdat,
    output logic [DATA_WIDTH-1:0] ld_rdat,
    output logic [31:0]           instret,
    output logic                  err
);

    localparam logic [DATA_WIDTH-1:0] NOP_W = DATA_WIDTH'(NOP_INSTR);

    logic [2:0]            state_q, state_d;
    logic [DATA_WIDTH-1:0] ir_q, ir_d;
    logic [DATA_WIDTH-1:0] dr_q, dr_d;
    logic                  err_q, err_d;
    logic                  commit;

    // Memory mux, core handshake and next-state logic, all keyed on state.
    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        dr_d      = dr_q;
        err_d     = err_q;
        m_addr    = c_i_r_addr;
        m_en      = 1'b0;
        m_we      = 4'h0;
        m_wdat    = c_d_w_dat;
        c_i_r_dat = ir_q;
        commit    = 1'b0;
        ld_ready  = 1'b0;

        case (state_q)
            S_IDLE: begin
                ld_ready  = 1'b1;
                m_addr    = ld_addr;
                m_en      = ld_en;
                m_we      = full_lanes(ld_en & ld_we);
                m_wdat    = ld_wdat;
                c_i_r_dat = NOP_W;
                if (run) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                m_en      = 1'b1;
                c_i_r_dat = NOP_W;
                state_d   = S_IWAIT;
            end
            S_IWAIT: begin
                ir_d      = m_rdat;
                c_i_r_dat = NOP_W;
                state_d   = S_EXEC;
            end
            S_EXEC: begin
                if (c_d_w_enb) begin
                    // A store wins over a simultaneous load; the clash is flagged.
                    m_addr = c_d_w_addr;
                    m_en   = 1'b1;
                    m_we   = c_d_w_byte_enb;
                    commit = 1'b1;
                    if (c_d_r_enb) begin
                        err_d = 1'b1;
                    end
                end else if (c_d_r_enb) begin
                    m_addr  = c_d_r_addr;
                    m_en    = 1'b1;
                    state_d = S_DWAIT;
                end else begin
                    commit = 1'b1;
                end
            end
            S_DWAIT: begin
                dr_d    = m_rdat;
                state_d = S_COMMIT;
            end
            S_COMMIT: begin
                commit = 1'b1;
            end
            default: begin
                c_i_r_dat = NOP_W;
                state_d   = S_IDLE;
            end
        endcase

        // Halting only happens at an instruction boundary.
        if (commit) begin
            state_d = run ? S_FETCH : S_IDLE;
        end

        // The loader may only touch memory while the core is parked.
        if (ld_en && (state_q != S_IDLE)) begin
            err_d = 1'b1;
        end

        // Nothing reaches the BRAM or the core while reset is held.
        if (!rst) begin
            m_en      = 1'b0;
            m_we      = 4'h0;
            commit    = 1'b0;
            ld_ready  = 1'b0;
            c_i_r_dat = NOP_W;
        end
    end

    // State, instruction/data holding registers and sticky error flag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            ir_q    <= NOP_W;
            dr_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            dr_q    <= dr_d;
            err_q   <= err_d;
        end
    end

    retire_counter u_retire_counter (
        .clk   (clk),
        .clr_n (rst),
        .en    (commit),
        .count (instret)
    );

    assign pc_stall  = ~commit;
    assign wb_en     = commit;
    assign c_d_r_dat = dr_q;
    assign ld_rdat   = m_rdat;
    assign err       = err_q;

endmodule

// File: tb/tb_mem_sequencer.sv
// Self-checking bench for mem_sequencer: a BRAM model, a word-level reference
// memory, and per-instruction expectations (latency, instruction, load data,
// store lanes, retire count) derived from the instruction kind.
module tb_mem_sequencer;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam logic [31:0] NOP = 32'h00000013;

    logic          clk = 1'b0;
    logic          rst;
    logic          run;
    logic [AW-1:0] c_i_r_addr;
    logic [DW-1:0] c_i_r_dat;
    logic [AW-1:0] c_d_r_addr;
    logic          c_d_r_enb;
    logic [DW-1:0] c_d_r_dat;
    logic [AW-1:0] c_d_w_addr;
    logic [DW-1:0] c_d_w_dat;
    logic          c_d_w_enb;
    logic [3:0]    c_d_w_byte_enb;
    logic          pc_stall;
    logic          wb_en;
    logic [AW-1:0] m_addr;
    logic          m_en;
    logic [3:0]    m_we;
    logic [DW-1:0] m_wdat;
    logic [DW-1:0] m_rdat;
    logic          ld_ready;
    logic          ld_en;
    logic          ld_we;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_wdat;
    logic [DW-1:0] ld_rdat;
    logic [31:0]   instret;
    logic          err;

    int n_checks = 0;
    int n_errors = 0;
    int exp_instret = 0;

    logic [31:0] mem     [0:1023];
    logic [31:0] ref_mem [0:1023];

    always #5 clk = ~clk;

    mem_sequencer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst), .run(run),
        .c_i_r_addr(c_i_r_addr), .c_i_r_dat(c_i_r_dat),
        .c_d_r_addr(c_d_r_addr), .c_d_r_enb(c_d_r_enb), .c_d_r_dat(c_d_r_dat),
        .c_d_w_addr(c_d_w_addr), .c_d_w_dat(c_d_w_dat), .c_d_w_enb(c_d_w_enb),
        .c_d_w_byte_enb(c_d_w_byte_enb),
        .pc_stall(pc_stall), .wb_en(wb_en),
        .m_addr(m_addr), .m_en(m_en), .m_we(m_we), .m_wdat(m_wdat), .m_rdat(m_rdat),
        .ld_ready(ld_ready), .ld_en(ld_en), .ld_we(ld_we), .ld_addr(ld_addr),
        .ld_wdat(ld_wdat), .ld_rdat(ld_rdat),
        .instret(instret), .err(err)
    );

    // Single-port BRAM, read-first, one-cycle read latency, byte write lanes.
    always @(posedge clk) begin
        if (m_en) begin
            m_rdat <= mem[m_addr[AW-1:2]];
            for (int b = 0; b < 4; b++) begin
                if (m_we[b]) mem[m_addr[AW-1:2]][b*8 +: 8] <= m_wdat[b*8 +: 8];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic loader_write(input logic [AW-1:0] a, input logic [31:0] d);
        ld_en = 1'b1; ld_we = 1'b1; ld_addr = a; ld_wdat = d;
        #1;
        check("ld_wr_we", 32'(m_we), 32'hF);
        check("ld_wr_addr", 32'(m_addr), 32'(a));
        @(negedge clk);
        ld_en = 1'b0; ld_we = 1'b0;
        ref_mem[a[AW-1:2]] = d;
        $display("loader write addr=%h data=%h", a, d);
    endtask

    task automatic loader_read(input logic [AW-1:0] a, output logic [31:0] d);
        ld_en = 1'b1; ld_we = 1'b0; ld_addr = a;
        #1;
        check("ld_rd_we", 32'(m_we), 32'h0);
        @(negedge clk);
        ld_en = 1'b0;
        #1;
        d = ld_rdat;
        $display("loader read  addr=%h data=%h", a, d);
    endtask

    // From IDLE: raise run and step into FETCH.
    task automatic start_run();
        check("idle_ready", 32'(ld_ready), 32'h1);
        check("idle_nop", c_i_r_dat, NOP);
        run = 1'b1;
        @(negedge clk);
    endtask

    // One instruction starting in FETCH. kind: 0 alu, 1 load, 2 store, 3 load+store.
    task automatic run_instr(input int kind, input logic [AW-1:0] pc, input logic [AW-1:0] daddr,
                             input logic [31:0] wdat, input logic [3:0] be,
                             input bit run_v, input bit drop_mid);
        int cyc = 0;
        int nwe = 0;
        int exp_lat;
        bit done = 0;
        logic [31:0] exp_ir, exp_ld;
        exp_ir  = ref_mem[pc[AW-1:2]];
        exp_ld  = ref_mem[daddr[AW-1:2]];
        exp_lat = (kind == 1) ? 5 : 3;
        c_i_r_addr = pc; c_d_r_addr = daddr; c_d_w_addr = daddr;
        c_d_w_dat = wdat; c_d_w_byte_enb = be;
        c_d_r_enb = (kind == 1 || kind == 3);
        c_d_w_enb = (kind >= 2);
        run = run_v;
        while (!done && cyc < 12) begin
            if (drop_mid && cyc == 3) run = 1'b0;
            #1;
            cyc++;
            if (m_we != 4'h0) nwe++;
            if (cyc == 1) check("fetch_addr", 32'(m_addr), 32'(pc));
            if (cyc == 3 && kind != 0) check("exec_daddr", 32'(m_addr), 32'(daddr));
            if (!pc_stall) begin
                done = 1;
                check("latency", cyc, exp_lat);
                check("commit_ir", c_i_r_dat, exp_ir);
                check("commit_wb", 32'(wb_en), 32'h1);
                if (kind == 1) check("load_data", c_d_r_dat, exp_ld);
                if (kind >= 2) check("store_we", 32'(m_we), 32'(be));
            end
            @(negedge clk);
        end
        check("commit_seen", 32'(done), 32'h1);
        if (kind >= 2) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) ref_mem[daddr[AW-1:2]][b*8 +: 8] = wdat[b*8 +: 8];
        end
        exp_instret++;
        check("instret", instret, 32'(exp_instret));
        check("we_cycles", nwe, (kind >= 2) ? 1 : 0);
        if (kind == 3) check("both_err", 32'(err), 32'h1);
        c_d_r_enb = 1'b0; c_d_w_enb = 1'b0;
        $display("instr kind=%0d pc=%h daddr=%h lat=%0d instret=%0d", kind, pc, daddr, cyc, instret);
    endtask

    initial begin
        logic [31:0] rd;
        logic [AW-1:0] pc, da;
        int kind;
        for (int i = 0; i < 1024; i++) begin
            mem[i] = '0;
            ref_mem[i] = '0;
        end
        rst = 1'b0; run = 1'b1;
        c_i_r_addr = '0; c_d_r_addr = '0; c_d_r_enb = 1'b0;
        c_d_w_addr = '0; c_d_w_dat = '0; c_d_w_enb = 1'b0; c_d_w_byte_enb = '0;
        ld_en = 1'b1; ld_we = 1'b1; ld_addr = 12'h040; ld_wdat = 32'hFFFF_FFFF;

        // Reset held for three cycles with run high and a loader strobe present.
        repeat (3) begin
            @(negedge clk);
            #1;
            check("rst_stall", 32'(pc_stall), 32'h1);
            check("rst_wb", 32'(wb_en), 32'h0);
            check("rst_men", 32'(m_en), 32'h0);
            check("rst_mwe", 32'(m_we), 32'h0);
            check("rst_instret", instret, 32'h0);
            check("rst_ir", c_i_r_dat, NOP);
            check("rst_err", 32'(err), 32'h0);
        end
        ld_en = 1'b0; ld_we = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("post_rst_idle", 32'(ld_ready), 32'h1);
        check("post_rst_stall", 32'(pc_stall), 32'h1);
        @(negedge clk);
        check("fetch_not_ready", 32'(ld_ready), 32'h0);
        run_instr(0, 12'h000, 12'h000, 32'h0, 4'h0, 1'b0, 1'b0);
        check("halt_idle", 32'(ld_ready), 32'h1);

        // Loader: directed program, a load target, then random contents.
        loader_write(12'h000, 32'h00500093);
        loader_read(12'h000, rd);
        check("ld_readback", rd, 32'h00500093);
        loader_write(12'h004, 32'h00100113);
        loader_write(12'h100, 32'hDEADBEEF);
        for (int i = 2; i < 32; i++) loader_write(12'(i * 4), $urandom);
        for (int i = 0; i < 32; i++) loader_write(12'(12'h200 + i * 4), $urandom);

        // Two ALU instructions back to back, then a load that halts.
        start_run();
        run_instr(0, 12'h000, 12'h000, 32'h0, 4'h0, 1'b1, 1'b0);
        run_instr(0, 12'h004, 12'h000, 32'h0, 4'h0, 1'b1, 1'b0);
        run_instr(1, 12'h008, 12'h100, 32'h0, 4'h0, 1'b0, 1'b0);

        // Half-word store then loader readback.
        start_run();
        run_instr(2, 12'h00C, 12'h200, 32'h0000ABCD, 4'b0011, 1'b0, 1'b0);
        loader_read(12'h200, rd);
        check("store_low_half", {16'h0, rd[15:0]}, 32'h0000ABCD);
        check("store_word", rd, ref_mem[12'h200 >> 2]);

        // Randomized instruction stream.
        start_run();
        for (int i = 0; i < 60; i++) begin
            kind = int'($urandom_range(0, 2));
            pc = 12'($urandom_range(0, 31) * 4);
            da = 12'(12'h200 + $urandom_range(0, 31) * 4);
            run_instr(kind, pc, da, $urandom, 4'($urandom_range(1, 15)), (i != 59), 1'b0);
        end
        check("rand_idle", 32'(ld_ready), 32'h1);
        for (int i = 0; i < 32; i++) begin
            loader_read(12'(12'h200 + i * 4), rd);
            check("rand_mem", rd, ref_mem[128 + i]);
        end

        // run dropped during a load's data wait.
        start_run();
        run_instr(1, 12'h010, 12'h204, 32'h0, 4'h0, 1'b1, 1'b1);
        check("drop_idle", 32'(ld_ready), 32'h1);

        // Loader strobe during FETCH is ignored and flagged.
        check("err_before", 32'(err), 32'h0);
        run = 1'b1;
        c_i_r_addr = 12'h014;
        @(negedge clk);
        ld_en = 1'b1; ld_we = 1'b1; ld_addr = 12'h300; ld_wdat = 32'h12345678;
        #1;
        check("ld_ignored_we", 32'(m_we), 32'h0);
        check("ld_ignored_addr", 32'(m_addr), 32'h014);
        @(negedge clk);
        ld_en = 1'b0; ld_we = 1'b0; run = 1'b0;
        check("err_set", 32'(err), 32'h1);
        begin
            bit seen = 0;
            for (int i = 0; i < 10 && !seen; i++) begin
                #1;
                if (!pc_stall) seen = 1;
                @(negedge clk);
            end
            check("err_instr_commit", 32'(seen), 32'h1);
        end
        exp_instret++;
        check("err_instret", instret, 32'(exp_instret));
        repeat (3) @(negedge clk);
        check("err_sticky", 32'(err), 32'h1);
        check("ld_ignored_mem", mem[12'h300 >> 2], 32'h0);

        // Reset clears err and instret.
        rst = 1'b0;
        @(negedge clk);
        check("rst_clr_err", 32'(err), 32'h0);
        check("rst_clr_instret", instret, 32'h0);
        exp_instret = 0;
        rst = 1'b1;
        @(negedge clk);

        // Load and store together: store wins, err raised.
        start_run();
        run_instr(3, 12'h014, 12'h208, 32'hCAFEF00D, 4'hF, 1'b0, 1'b0);
        loader_read(12'h208, rd);
        check("both_store_data", rd, 32'hCAFEF00D);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
